// File: rtl/pitchdetect.sv
// pitchdetect: frame-based pitch and voicing analyser.
// Consumes a signed sample stream and, once every lpcrate accepted samples,
// reports the pitch period estimate (pulserate) and a voiced flag (v).
//   clk, rst          clock, asynchronous active-low reset
//   din, din_valid    signed sample and its accept strobe
//   lpcrate           frame length in samples (0 acts as 1), latched per frame
//   energy_thresh     minimum frame magnitude sum for voiced
//   zc_max            maximum zero crossings per frame for voiced
//   pulserate, v      per-frame results, held between frames
//   frame_valid       one-cycle strobe when pulserate/v update
module pitchdetect #(
  parameter int MINPER = 20,
  parameter int MAXPER = 320,
  parameter int MINAMP = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] din,
  input  logic               din_valid,
  input  logic        [15:0] lpcrate,
  input  logic        [31:0] energy_thresh,
  input  logic        [15:0] zc_max,
  output logic        [15:0] pulserate,
  output logic               v,
  output logic               frame_valid
);
  typedef enum logic {COLLECT = 1'b0, DECIDE = 1'b1} state_t;

  localparam logic [15:0] MIN_P = 16'(MINPER);
  localparam logic [15:0] MAX_P = 16'(MAXPER);
  localparam logic [15:0] SAT_P = 16'(MAXPER + 1);
  localparam logic [15:0] MIN_A = 16'(MINAMP);

  state_t             state_q, state_d;
  logic               load_q, load_d;          // first edge after reset latches lpcrate
  logic        [15:0] len_q, len_d;
  logic        [15:0] cnt_q, cnt_d;
  logic        [31:0] energy_q, energy_d;
  logic        [15:0] zc_q, zc_d;
  logic        [15:0] max_q, max_d;
  logic signed [15:0] prev_q, prev_d;
  logic        [15:0] int_cnt_q, int_cnt_d;
  logic        [15:0] last_int_q, last_int_d;
  logic               have_int_q, have_int_d;
  logic        [15:0] pfm_q, pfm_d;            // previous frame max magnitude
  logic        [31:0] snap_e_q, snap_e_d;
  logic        [15:0] snap_zc_q, snap_zc_d;
  logic        [15:0] snap_max_q, snap_max_d;
  logic        [15:0] snap_int_q, snap_int_d;
  logic               snap_have_q, snap_have_d;
  logic        [15:0] pulserate_q, pulserate_d;
  logic               v_q, v_d;
  logic               fv_q, fv_d;

  logic        [15:0] len_cur, len_eff, mag, half, thr;
  logic               marker, in_range, last;
  logic        [31:0] e_nxt;
  logic        [15:0] zc_nxt, max_nxt, li_nxt;
  logic               hv_nxt;

  always_comb begin
    len_cur  = load_q ? lpcrate : len_q;
    len_eff  = (len_cur == 16'd0) ? 16'd1 : len_cur;
    // |-32768| wraps to 0x8000, which is 32768 read as unsigned
    mag      = din[15] ? (~din + 16'd1) : din;
    half     = {1'b0, pfm_q[15:1]};
    thr      = (half > MIN_A) ? half : MIN_A;
    // thr is zero-extended so the sample compare stays signed
    marker   = ($signed({prev_q[15], prev_q}) < $signed({1'b0, thr})) &&
               ($signed({din[15], din}) >= $signed({1'b0, thr}));
    in_range = (int_cnt_q >= MIN_P) && (int_cnt_q <= MAX_P);
    last     = din_valid && (({1'b0, cnt_q} + 17'd1) == {1'b0, len_eff});

    e_nxt    = energy_q + {16'd0, mag};
    zc_nxt   = ((din[15] != prev_q[15]) && (zc_q != 16'hFFFF)) ? zc_q + 16'd1 : zc_q;
    max_nxt  = (mag > max_q) ? mag : max_q;
    li_nxt   = last_int_q;
    hv_nxt   = have_int_q;
    if (marker && in_range) begin
      li_nxt = int_cnt_q;
      hv_nxt = 1'b1;
    end

    state_d     = COLLECT;
    load_d      = 1'b0;
    len_d       = len_cur;
    cnt_d       = cnt_q;
    energy_d    = energy_q;
    zc_d        = zc_q;
    max_d       = max_q;
    prev_d      = prev_q;
    int_cnt_d   = int_cnt_q;
    last_int_d  = last_int_q;
    have_int_d  = have_int_q;
    pfm_d       = pfm_q;
    snap_e_d    = snap_e_q;
    snap_zc_d   = snap_zc_q;
    snap_max_d  = snap_max_q;
    snap_int_d  = snap_int_q;
    snap_have_d = snap_have_q;
    pulserate_d = pulserate_q;
    v_d         = v_q;
    fv_d        = (state_q == DECIDE);

    // Accumulation runs independent of state so a DECIDE-cycle sample
    // simply opens the new frame.
    if (din_valid) begin
      cnt_d      = cnt_q + 16'd1;
      energy_d   = e_nxt;
      zc_d       = zc_nxt;
      max_d      = max_nxt;
      prev_d     = din;
      last_int_d = li_nxt;
      have_int_d = hv_nxt;
      if (marker)                 int_cnt_d = 16'd1;
      else if (int_cnt_q >= SAT_P) int_cnt_d = SAT_P;
      else                        int_cnt_d = int_cnt_q + 16'd1;
      if (last) begin
        // snapshot includes this sample (and a marker landing on it)
        snap_e_d    = e_nxt;
        snap_zc_d   = zc_nxt;
        snap_max_d  = max_nxt;
        snap_int_d  = li_nxt;
        snap_have_d = hv_nxt;
        cnt_d       = 16'd0;
        energy_d    = 32'd0;
        zc_d        = 16'd0;
        max_d       = 16'd0;
        have_int_d  = 1'b0;
        len_d       = lpcrate;
        state_d     = DECIDE;
      end
    end

    if (state_q == DECIDE) begin
      v_d   = (snap_e_q >= energy_thresh) && (snap_zc_q <= zc_max) && snap_have_q;
      if (snap_have_q) pulserate_d = snap_int_q;
      pfm_d = snap_max_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      load_q      <= 1'b1;
      len_q       <= 16'd1;
      cnt_q       <= '0;
      energy_q    <= '0;
      zc_q        <= '0;
      max_q       <= '0;
      prev_q      <= '0;
      int_cnt_q   <= SAT_P;
      last_int_q  <= '0;
      have_int_q  <= 1'b0;
      pfm_q       <= '0;
      snap_e_q    <= '0;
      snap_zc_q   <= '0;
      snap_max_q  <= '0;
      snap_int_q  <= '0;
      snap_have_q <= 1'b0;
      pulserate_q <= '0;
      v_q         <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      energy_q    <= energy_d;
      zc_q        <= zc_d;
      max_q       <= max_d;
      prev_q      <= prev_d;
      int_cnt_q   <= int_cnt_d;
      last_int_q  <= last_int_d;
      have_int_q  <= have_int_d;
      pfm_q       <= pfm_d;
      snap_e_q    <= snap_e_d;
      snap_zc_q   <= snap_zc_d;
      snap_max_q  <= snap_max_d;
      snap_int_q  <= snap_int_d;
      snap_have_q <= snap_have_d;
      pulserate_q <= pulserate_d;
      v_q         <= v_d;
      fv_q        <= fv_d;
    end
  end

  assign pulserate   = pulserate_q;
  assign v           = v_q;
  assign frame_valid = fv_q;
endmodule

// File: tb/tb_pitchdetect.sv
// Bench for pitchdetect: scenario tasks plus randomized traffic, all checked
// against a sample-index based reference model of the analyser.
module tb_pitchdetect;
  localparam int MINPER = 20;
  localparam int MAXPER = 320;
  localparam int MINAMP = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] din = '0;
  logic               din_valid = 1'b0;
  logic        [15:0] lpcrate = 16'd240;
  logic        [31:0] energy_thresh = 32'd10000;
  logic        [15:0] zc_max = 16'd60;
  logic        [15:0] pulserate;
  logic               v;
  logic               frame_valid;

  int total = 0;
  int bad = 0;

  pitchdetect #(.MINPER(MINPER), .MAXPER(MAXPER), .MINAMP(MINAMP)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .lpcrate(lpcrate),
    .energy_thresh(energy_thresh), .zc_max(zc_max), .pulserate(pulserate),
    .v(v), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // reference model state
  bit     m_load, m_pend, m_hmk, m_hint, s_have;
  int     m_len, m_cnt, m_zc, m_max, m_prev, m_pfm, m_lint;
  longint m_e, m_idx, m_lmk, s_e;
  int     s_zc, s_max, s_int;
  int     m_pr;
  bit     m_v, m_fv;

  task automatic model_reset();
    m_load = 1; m_pend = 0; m_hmk = 0; m_hint = 0; s_have = 0;
    m_len = 1; m_cnt = 0; m_zc = 0; m_max = 0; m_prev = 0; m_pfm = 0; m_lint = 0;
    m_e = 0; m_idx = 0; m_lmk = 0; s_e = 0; s_zc = 0; s_max = 0; s_int = 0;
    m_pr = 0; m_v = 0; m_fv = 0;
  endtask

  task automatic model_edge(input int d, input bit vld);
    bit     op = m_pend, oh = s_have;
    longint oe = s_e;
    int     ozc = s_zc, omax = s_max, oint = s_int;
    int     a, thr;
    m_pend = 0;
    if (m_load) begin m_len = (lpcrate == 0) ? 1 : int'(lpcrate); m_load = 0; end
    if (vld) begin
      a   = (d < 0) ? -d : d;
      thr = (m_pfm / 2 > MINAMP) ? m_pfm / 2 : MINAMP;
      if (m_prev < thr && d >= thr) begin
        if (m_hmk && (m_idx - m_lmk) >= MINPER && (m_idx - m_lmk) <= MAXPER) begin
          m_hint = 1; m_lint = int'(m_idx - m_lmk);
        end
        m_lmk = m_idx; m_hmk = 1;
      end
      if (((d < 0) != (m_prev < 0)) && m_zc < 65535) m_zc++;
      m_e += a;
      if (a > m_max) m_max = a;
      m_prev = d; m_idx++; m_cnt++;
      if (m_cnt == m_len) begin
        m_pend = 1; s_e = m_e; s_zc = m_zc; s_max = m_max; s_have = m_hint; s_int = m_lint;
        m_cnt = 0; m_e = 0; m_zc = 0; m_max = 0; m_hint = 0;
        m_len = (lpcrate == 0) ? 1 : int'(lpcrate);
      end
    end
    m_fv = op;
    if (op) begin
      m_v = (oe >= longint'(energy_thresh)) && (ozc <= int'(zc_max)) && oh;
      if (oh) m_pr = oint;
      m_pfm = omax;
    end
  endtask

  task automatic step(input logic signed [15:0] d, input logic vld);
    din = d; din_valid = vld;
    @(posedge clk);
    model_edge(int'(d), vld);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; din_valid = 0; din = '0;
    #1 model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    lpcrate = 16'd240; energy_thresh = 32'd10000; zc_max = 16'd60;
    rst = 0; din_valid = 0;
    #1 model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({frame_valid, v, pulserate} !== 18'd0) begin
      bad++; $display("FAIL reset_state got fv=%b v=%b pr=%0d want 0/0/0", frame_valid, v, pulserate);
    end
    rst = 1;
    step(16'sd0, 1'b0);
    total++;
    if ({frame_valid, v, pulserate} !== 18'd0) begin
      bad++; $display("FAIL reset_idle got fv=%b v=%b pr=%0d want 0/0/0", frame_valid, v, pulserate);
    end
  endtask

  task automatic test_voiced();
    bit seen = 0;
    for (int i = 0; i < 720; i++) begin
      step((i % 80 == 0) ? 16'sd8000 : 16'sd0, 1'b1);
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL voiced cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i + 1, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid && !seen) begin
        seen = 1; total++;
        if (i + 1 != 241 || pulserate !== 16'd80 || v !== 1'b1) begin
          bad++; $display("FAIL voiced_first got cyc=%0d pr=%0d v=%b want cyc=241 pr=80 v=1",
                          i + 1, pulserate, v);
        end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL voiced_first got no frame_valid want one at 241"); end
  endtask

  task automatic test_silence();
    for (int i = 0; i < 720; i++) begin
      step(16'sd0, 1'b1);
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL silence cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid && i > 0) begin
        total++;
        if (v !== 1'b0 || pulserate !== 16'd80) begin
          bad++; $display("FAIL silence_frame got v=%b pr=%0d want v=0 pr=80", v, pulserate);
        end
      end
    end
  endtask

  task automatic test_noise();
    for (int i = 0; i < 720; i++) begin
      step((i % 2 == 0) ? 16'sd1000 : -16'sd1000, 1'b1);
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL noise cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid && i > 0) begin
        total++;
        if (v !== 1'b0) begin bad++; $display("FAIL noise_frame got v=%b want v=0", v); end
      end
    end
  endtask

  task automatic test_long_period();
    do_reset();
    for (int i = 0; i < 960; i++) begin
      step((i % 400 == 0) ? 16'sd8000 : 16'sd0, 1'b1);
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL long_period cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid) begin
        total++;
        if (v !== 1'b0 || pulserate !== 16'd0) begin
          bad++; $display("FAIL long_period_frame got v=%b pr=%0d want v=0 pr=0", v, pulserate);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 340; i++) step((i % 80 == 0) ? 16'sd8000 : 16'sd0, 1'b1);
    total++;
    if (pulserate !== 16'(m_pr) || m_pr != 80) begin
      bad++; $display("FAIL midreset_pre got pr=%0d want pr=80 (model %0d)", pulserate, m_pr);
    end
    rst = 0;
    #1;
    total++;
    if ({frame_valid, v, pulserate} !== 18'd0) begin
      bad++; $display("FAIL midreset_async got fv=%b v=%b pr=%0d want 0/0/0", frame_valid, v, pulserate);
    end
    model_reset();
    din_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    while (cyc < 400) begin
      step((cyc % 80 == 0) ? 16'sd8000 : 16'sd0, 1'b1);
      cyc++;
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL midreset cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        cyc, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid) break;
    end
    total++;
    if (cyc != 241) begin bad++; $display("FAIL midreset_frame got cyc=%0d want 241", cyc); end
  endtask

  task automatic test_gapped();
    int acc = 0, acc_before, lastb = 0, nf = 0, sz, want;
    bit vld;
    do_reset();
    lpcrate = 16'd240;
    for (int i = 0; i < 3000 && nf < 3; i++) begin
      vld = m_pend ? 1'b1 : 1'($urandom % 2);
      if (acc == 100) lpcrate = 16'd160;
      acc_before = acc;
      step(16'($urandom), vld);
      if (vld) acc++;
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL gapped cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
      if (frame_valid) begin
        sz = acc_before - lastb; want = (nf == 0) ? 240 : 160;
        total++;
        if (sz != want) begin bad++; $display("FAIL gapped_len frame=%0d got %0d want %0d", nf, sz, want); end
        lastb = acc_before; nf++;
      end
    end
    if (nf < 3) begin total++; bad++; $display("FAIL gapped_timeout got %0d frames want 3", nf); end
  endtask

  task automatic test_random();
    logic signed [15:0] d;
    do_reset();
    lpcrate = 16'd3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        lpcrate = 16'($urandom_range(0, 6));
        energy_thresh = 32'($urandom_range(0, 40000));
        zc_max = 16'($urandom_range(0, 4));
      end
      case ($urandom % 6)
        0: d = 16'sd0;
        1: d = -16'sd32768;
        2: d = 16'sd32767;
        3: d = 16'($urandom);
        4: d = 16'($urandom_range(0, 600) - 300);
        default: d = 16'sd8000;
      endcase
      step(d, ($urandom % 4) != 0);
      total++;
      if ({frame_valid, v, pulserate} !== {m_fv, m_v, 16'(m_pr)}) begin
        bad++; $display("FAIL random cyc=%0d got fv=%b v=%b pr=%0d want fv=%b v=%b pr=%0d",
                        i, frame_valid, v, pulserate, m_fv, m_v, m_pr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_voiced();
    test_silence();
    test_noise();
    test_long_period();
    test_reset_midframe();
    test_gapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
